// File: rtl/bcd_conv_responder.sv
// bcd_conv_responder: soc/eoc converter stand-in returning one BCD digit per request.
// Define BCD_CONV_LFSR_LATENCY_EN to stretch each conversion by a 3-bit LFSR value.
module bcd_conv_responder #(
   parameter int ACK_DELAY   = 1,
   parameter int CONV_CYCLES = 4,
   parameter int OFFSET      = 5,
   parameter int MULT        = 19,
   parameter int DIGIT       = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       soc,
   output logic       eoc,
   output logic [3:0] data,
   output logic [4:0] index,
   output logic       proto_err
);
   localparam logic [1:0] IDLE = 2'd0, ACK = 2'd1, BUSY = 2'd2, CONV = 2'd3;
   logic [1:0]  state;
   logic [8:0]  cnt;
   logic [8:0]  conv_len;
   logic [4:0]  idx;
   logic [15:0] v;
   logic [3:0]  digit;
   logic        done;
   assign done = state == CONV && cnt == 9'd0;
`ifdef BCD_CONV_LFSR_LATENCY_EN
   logic [2:0] lfsr;
   always_ff @(posedge clock)
      if (reset) lfsr <= 3'b001;
      else if (done) lfsr <= {lfsr[0] ^ lfsr[2], lfsr[2:1]};
   assign conv_len = 9'(CONV_CYCLES - 1) + {6'd0, lfsr};
`else
   assign conv_len = 9'(CONV_CYCLES - 1);
`endif
   always_comb begin
      v = ((16'(idx) + 16'(OFFSET)) * 16'(MULT)) % 16'd100;
      digit = DIGIT != 0 ? 4'(v / 16'd10) : 4'(v % 16'd10);
   end
   assign eoc = state == IDLE || state == ACK;
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 9'd0;
         idx       <= 5'd0;
         data      <= 4'd0;
         index     <= 5'd0;
         proto_err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (soc) begin
               cnt   <= 9'(ACK_DELAY);
               state <= ACK_DELAY == 0 ? BUSY : ACK;
            end
            ACK: begin
               cnt <= cnt - 9'd1;
               if (!soc) proto_err <= 1'b1;
               if (cnt == 9'd1) state <= BUSY;
            end
            BUSY: if (!soc) begin
               cnt   <= conv_len;
               state <= CONV;
            end
            default: begin
               if (soc) proto_err <= 1'b1;
               if (done) begin
                  data  <= digit;
                  index <= idx;
                  idx   <= idx + 5'd1;
                  state <= IDLE;
               end else cnt <= cnt - 9'd1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_conv_responder.sv
// tb_bcd_conv_responder: directed checks of handshake timing, sample sequence and protocol errors.
module tb_bcd_conv_responder;
   logic clock = 1'b0, reset = 1'b1, soc_a = 1'b0, soc_b = 1'b0;
   logic eoc0, eoc1, eoc2, perr0, perr1, perr2;
   logic [3:0] data0, data1, data2;
   logic [4:0] index0, index1, index2;
   int errors = 0, checks = 0, nconv = 0;
   always #5 clock = ~clock;
   bcd_conv_responder u0 (.clock(clock), .reset(reset), .soc(soc_a), .eoc(eoc0),
      .data(data0), .index(index0), .proto_err(perr0));
   bcd_conv_responder #(.DIGIT(0)) u1 (.clock(clock), .reset(reset), .soc(soc_a), .eoc(eoc1),
      .data(data1), .index(index1), .proto_err(perr1));
   bcd_conv_responder #(.ACK_DELAY(3)) u2 (.clock(clock), .reset(reset), .soc(soc_b), .eoc(eoc2),
      .data(data2), .index(index2), .proto_err(perr2));
   function automatic int exp_lat(int k);
`ifdef BCD_CONV_LFSR_LATENCY_EN
      int t[7] = '{1, 4, 6, 7, 3, 5, 2};
      return 4 + t[k % 7];
`else
      return 4 + 0 * k;
`endif
   endfunction
   task automatic apply_reset();
      @(negedge clock) reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      nconv = 0;
   endtask
   task automatic do_conv(output int ack, output int lat);
      soc_a = 1'b1;
      @(posedge clock);
      ack = 0;
      @(negedge clock);
      while (eoc0 && ack < 50) begin @(negedge clock); ack++; end
      soc_a = 1'b0;
      @(posedge clock);
      lat = 0;
      @(negedge clock);
      while (!eoc0 && lat < 50) begin @(negedge clock); lat++; end
   endtask
   task automatic test_reset();
      apply_reset();
      checks++; if (eoc0 !== 1'b1) begin errors++; $display("FAIL reset_eoc got %b want 1", eoc0); end
      checks++; if (data0 !== 4'd0) begin errors++; $display("FAIL reset_data got %0d want 0", data0); end
      checks++; if (index0 !== 5'd0) begin errors++; $display("FAIL reset_index got %0d want 0", index0); end
      checks++; if (perr0 !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", perr0); end
      checks++; if (eoc2 !== 1'b1) begin errors++; $display("FAIL reset_eoc2 got %b want 1", eoc2); end
   endtask
   task automatic test_single();
      int ack, lat;
      do_conv(ack, lat);
      checks++; if (ack !== 1) begin errors++; $display("FAIL single_ack got %0d want 1", ack); end
      checks++; if (lat !== exp_lat(nconv)) begin errors++; $display("FAIL single_lat got %0d want %0d", lat, exp_lat(nconv)); end
      checks++; if (data0 !== 4'd9) begin errors++; $display("FAIL single_tens got %0d want 9", data0); end
      checks++; if (index0 !== 5'd0) begin errors++; $display("FAIL single_index got %0d want 0", index0); end
      checks++; if (data1 !== 4'd5) begin errors++; $display("FAIL single_units got %0d want 5", data1); end
      checks++; if (perr0 !== 1'b0) begin errors++; $display("FAIL single_perr got %b want 0", perr0); end
      nconv++;
   endtask
   task automatic test_back_to_back();
      int ack, lat, v;
      apply_reset();
      for (int i = 0; i < 33; i++) begin
         do_conv(ack, lat);
         v = ((i % 32 + 5) * 19) % 100;
         checks++; if (lat !== exp_lat(nconv)) begin errors++; $display("FAIL seq_lat[%0d] got %0d want %0d", i, lat, exp_lat(nconv)); end
         checks++; if (data0 !== 4'(v / 10)) begin errors++; $display("FAIL seq_tens[%0d] got %0d want %0d", i, data0, v / 10); end
         checks++; if (data1 !== 4'(v % 10)) begin errors++; $display("FAIL seq_units[%0d] got %0d want %0d", i, data1, v % 10); end
         checks++; if (index0 !== 5'(i % 32)) begin errors++; $display("FAIL seq_index[%0d] got %0d want %0d", i, index0, i % 32); end
         if (i == 31) begin
            checks++; if (data0 !== 4'd8 || data1 !== 4'd4) begin errors++; $display("FAIL seq_idx31 got %0d%0d want 84", data0, data1); end
         end
         if (i == 32) begin
            checks++; if (data0 !== 4'd9 || index0 !== 5'd0) begin errors++; $display("FAIL seq_wrap got data %0d index %0d want 9 0", data0, index0); end
         end
         nconv++;
      end
   endtask
   task automatic test_conv_reraise();
      int n;
      soc_a = 1'b1;
      n = 0;
      @(negedge clock);
      while (eoc0 && n < 50) begin @(negedge clock); n++; end
      soc_a = 1'b0;
      @(posedge clock);
      @(negedge clock) soc_a = 1'b1;
      @(negedge clock) soc_a = 1'b0;
      n = 0;
      while (!eoc0 && n < 50) begin @(negedge clock); n++; end
      nconv++;
      checks++; if (eoc0 !== 1'b1) begin errors++; $display("FAIL reraise_eoc got %b want 1", eoc0); end
      checks++; if (perr0 !== 1'b1) begin errors++; $display("FAIL reraise_perr got %b want 1", perr0); end
   endtask
   task automatic test_mid_reset();
      int ack, lat, n;
      soc_a = 1'b1;
      n = 0;
      @(negedge clock);
      while (eoc0 && n < 50) begin @(negedge clock); n++; end
      soc_a = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (eoc0 !== 1'b0) begin errors++; $display("FAIL midrst_inconv got %b want 0", eoc0); end
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      checks++; if (eoc0 !== 1'b1 || data0 !== 4'd0 || index0 !== 5'd0) begin
         errors++; $display("FAIL midrst_state got eoc %b data %0d index %0d want 1 0 0", eoc0, data0, index0);
      end
      checks++; if (perr0 !== 1'b0) begin errors++; $display("FAIL midrst_perr got %b want 0", perr0); end
      reset = 1'b0;
      nconv = 0;
      @(negedge clock);
      do_conv(ack, lat);
      checks++; if (data0 !== 4'd9 || index0 !== 5'd0) begin
         errors++; $display("FAIL midrst_next got data %0d index %0d want 9 0", data0, index0);
      end
      nconv++;
   endtask
   task automatic test_proto_ack();
      int n, m;
      soc_b = 1'b1;
      @(posedge clock);
      @(negedge clock) soc_b = 1'b0;
      n = 0;
      while (eoc2 && n < 50) begin @(negedge clock); n++; end
      checks++; if (n !== 3) begin errors++; $display("FAIL proto_ack_lat got %0d want 3", n); end
      checks++; if (perr2 !== 1'b1) begin errors++; $display("FAIL proto_perr got %b want 1", perr2); end
      @(posedge clock);
      m = 0;
      @(negedge clock);
      while (!eoc2 && m < 50) begin @(negedge clock); m++; end
      checks++; if (m !== exp_lat(0)) begin errors++; $display("FAIL proto_conv_lat got %0d want %0d", m, exp_lat(0)); end
      checks++; if (data2 !== 4'd9) begin errors++; $display("FAIL proto_data got %0d want 9", data2); end
      repeat (5) @(negedge clock);
      checks++; if (perr2 !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b want 1", perr2); end
      apply_reset();
      checks++; if (perr2 !== 1'b0) begin errors++; $display("FAIL proto_clear got %b want 0", perr2); end
   endtask
   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_conv_reraise();
      test_mid_reset();
      test_proto_ack();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
